// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter: round-robin request arbiter and single-transaction snoop bus sequencer.
// Define SNOOP_BUS_ARB_PERF_EN to add the perf_txn_cnt/perf_busy_cnt counters.
module snoop_bus_arbiter #(
  parameter int NUM_PROCS = 4,
  parameter int ADDR_W    = 64,
  parameter int MEM_LAT   = 100,
  parameter int XFER_LAT  = 8,
  localparam int PW       = $clog2(NUM_PROCS)
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  logic [NUM_PROCS-1:0]          req_valid,
  input  logic [2*NUM_PROCS-1:0]        req_op,
  input  logic [NUM_PROCS*ADDR_W-1:0]   req_addr,
  output logic [NUM_PROCS-1:0]          req_ready,
  output logic                          bus_valid,
  output logic [1:0]                    bus_op,
  output logic [ADDR_W-1:0]             bus_addr,
  output logic [PW-1:0]                 bus_src,
  input  logic                          snoop_shared,
  input  logic                          snoop_supply,
  output logic                          done_valid,
  output logic [PW-1:0]                 done_proc,
  output logic                          done_shared
`ifdef SNOOP_BUS_ARB_PERF_EN
  ,
  output logic [31:0]                   perf_txn_cnt,
  output logic [31:0]                   perf_busy_cnt
`endif
);
  localparam int CW = $clog2((MEM_LAT > XFER_LAT ? MEM_LAT : XFER_LAT) + 1);
  typedef enum logic [2:0] {IDLE, BCAST, SNOOP, WAIT, DONE} state_e;
  state_e                state_q, state_d;
  logic [PW-1:0]         rr_ptr_q, src_q, gnt_idx;
  logic [1:0]            op_q;
  logic [ADDR_W-1:0]     addr_q;
  logic                  shared_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_PROCS-1:0]  elig;
  logic                  found, grant;
  // Scan starts one past the last winner so every requester gets a turn.
  always_comb begin
    elig    = '0;
    found   = 1'b0;
    gnt_idx = '0;
    for (int p = 0; p < NUM_PROCS; p++)
      elig[p] = req_valid[p] && req_op[2*p +: 2] != 2'd0;
    for (int i = 1; i <= NUM_PROCS; i++)
      if (!found && elig[(int'(rr_ptr_q) + i) % NUM_PROCS]) begin
        found   = 1'b1;
        gnt_idx = PW'((int'(rr_ptr_q) + i) % NUM_PROCS);
      end
  end
  assign grant     = rst_l && state_q == IDLE && found;
  assign req_ready = grant ? (NUM_PROCS'(1) << gnt_idx) : '0;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  state_d = grant ? BCAST : IDLE;
      BCAST: state_d = SNOOP;
      SNOOP: begin
        state_d = op_q == 2'd3 ? DONE : WAIT;
        cnt_d   = op_q == 2'd3 ? cnt_q : (snoop_supply ? CW'(XFER_LAT) : CW'(MEM_LAT));
      end
      WAIT: begin
        state_d = cnt_q == CW'(1) ? DONE : WAIT;
        cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= PW'(NUM_PROCS - 1);
      src_q    <= '0;
      op_q     <= '0;
      addr_q   <= '0;
      shared_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant) begin
        rr_ptr_q <= gnt_idx;
        src_q    <= gnt_idx;
        op_q     <= req_op[2*gnt_idx +: 2];
        addr_q   <= req_addr[ADDR_W*gnt_idx +: ADDR_W];
      end
      if (state_q == SNOOP) shared_q <= snoop_shared;
    end
  end
  assign bus_valid   = state_q == BCAST;
  assign bus_op      = op_q;
  assign bus_addr    = addr_q;
  assign bus_src     = src_q;
  assign done_valid  = state_q == DONE;
  assign done_proc   = src_q;
  assign done_shared = shared_q;
`ifdef SNOOP_BUS_ARB_PERF_EN
  logic [31:0] perf_txn_q, perf_busy_q;
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      perf_txn_q  <= '0;
      perf_busy_q <= '0;
    end else begin
      if (state_q == DONE) perf_txn_q <= perf_txn_q + 32'd1;
      if (state_q != IDLE) perf_busy_q <= perf_busy_q + 32'd1;
    end
  end
  assign perf_txn_cnt  = perf_txn_q;
  assign perf_busy_cnt = perf_busy_q;
`endif
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb_snoop_bus_arbiter: directed self-checking bench for snoop_bus_arbiter.
module tb_snoop_bus_arbiter;
  logic         clk = 1'b0;
  logic         rst_l = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [7:0]   req_op = '0;
  logic [255:0] req_addr = '0;
  logic [3:0]   req_ready;
  logic         bus_valid;
  logic [1:0]   bus_op;
  logic [63:0]  bus_addr;
  logic [1:0]   bus_src;
  logic         snoop_shared = 1'b0;
  logic         snoop_supply = 1'b0;
  logic         done_valid;
  logic [1:0]   done_proc;
  logic         done_shared;
`ifdef SNOOP_BUS_ARB_PERF_EN
  logic [31:0]  perf_txn_cnt, perf_busy_cnt;
`endif
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  snoop_bus_arbiter #(.NUM_PROCS(4), .ADDR_W(64), .MEM_LAT(100), .XFER_LAT(8)) dut (
    .clk(clk), .rst_l(rst_l), .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_ready(req_ready), .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr),
    .bus_src(bus_src), .snoop_shared(snoop_shared), .snoop_supply(snoop_supply),
    .done_valid(done_valid), .done_proc(done_proc), .done_shared(done_shared)
`ifdef SNOOP_BUS_ARB_PERF_EN
    , .perf_txn_cnt(perf_txn_cnt), .perf_busy_cnt(perf_busy_cnt)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int p, input logic [1:0] op, input logic [63:0] a);
    req_valid[p]        = 1'b1;
    req_op[2*p +: 2]    = op;
    req_addr[64*p +: 64] = a;
  endtask
  task automatic do_reset;
    rst_l = 1'b0;
    step;
    step;
    rst_l = 1'b1;
    step;
  endtask
  // Returns at the cycle after the grant with the winner's valid dropped.
  task automatic wait_grant(output int g, output int t);
    g = -1;
    t = -1;
    #1;
    for (int i = 0; i < 600 && g < 0; i++) begin
      if (req_ready != 4'b0) begin
        for (int p = 0; p < 4; p++) if (req_ready[p]) g = p;
        t = cyc;
      end else step;
    end
    if (g >= 0) begin
      step;
      req_valid[g] = 1'b0;
    end
  endtask
  task automatic wait_done(output int t, output logic [1:0] pr, output logic sh);
    t  = -1;
    pr = 2'bx;
    sh = 1'bx;
    for (int i = 0; i < 300 && t < 0; i++) begin
      if (done_valid) begin
        t  = cyc;
        pr = done_proc;
        sh = done_shared;
      end else step;
    end
    step;
  endtask
  task automatic test_reset;
    rst_l = 1'b0;
    step;
    step;
    checks++;
    if ({req_ready, bus_valid, bus_op, bus_addr, bus_src, done_valid, done_proc, done_shared} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b bv=%b op=%0d addr=%0h src=%0d dv=%b dp=%0d ds=%b exp all zero",
               req_ready, bus_valid, bus_op, bus_addr, bus_src, done_valid, done_proc, done_shared);
    end
    rst_l = 1'b1;
    step;
  endtask
  task automatic test_busrd;
    int g, t, td;
    logic [1:0] pr;
    logic sh;
    set_req(2, 2'd1, 64'h1000);
    wait_grant(g, t);
    checks++;
    if (g !== 2) begin errors++; $display("FAIL busrd_grant got %0d exp 2", g); end
    checks++;
    if ({bus_valid, bus_op, bus_addr, bus_src} !== {1'b1, 2'd1, 64'h1000, 2'd2}) begin
      errors++;
      $display("FAIL busrd_bcast got bv=%b op=%0d addr=%0h src=%0d exp bv=1 op=1 addr=1000 src=2", bus_valid, bus_op, bus_addr, bus_src);
    end
    checks++;
    if (req_ready !== 4'b0) begin errors++; $display("FAIL busrd_ready_low got %b exp 0000", req_ready); end
    step;
    checks++;
    if ({bus_valid, bus_addr} !== {1'b0, 64'h1000}) begin
      errors++;
      $display("FAIL busrd_bus_hold got bv=%b addr=%0h exp bv=0 addr=1000", bus_valid, bus_addr);
    end
    wait_done(td, pr, sh);
    checks++;
    if (td - t !== 103) begin errors++; $display("FAIL busrd_latency got %0d exp 103", td - t); end
    checks++;
    if ({pr, sh} !== {2'd2, 1'b0}) begin errors++; $display("FAIL busrd_done got proc=%0d sh=%b exp proc=2 sh=0", pr, sh); end
    checks++;
    if (done_valid !== 1'b0) begin errors++; $display("FAIL busrd_done_pulse got %b exp 0", done_valid); end
  endtask
  task automatic test_round_robin;
    int g0, t0, g1, t1, g3, t3, g4, t4, g5, t5, td;
    logic [1:0] pr;
    logic sh;
    do_reset;
    set_req(0, 2'd1, 64'h100);
    set_req(1, 2'd1, 64'h200);
    set_req(3, 2'd1, 64'h300);
    wait_grant(g0, t0);
    wait_grant(g1, t1);
    wait_grant(g3, t3);
    set_req(0, 2'd1, 64'h400);
    repeat (49) step;
    set_req(1, 2'd1, 64'h500);
    wait_grant(g4, t4);
    wait_grant(g5, t5);
    checks++;
    if ({g0, g1, g3, g4, g5} !== {32'd0, 32'd1, 32'd3, 32'd0, 32'd1}) begin
      errors++;
      $display("FAIL rr_order got %0d %0d %0d %0d %0d exp 0 1 3 0 1", g0, g1, g3, g4, g5);
    end
    checks++;
    if ({t1 - t0, t3 - t1, t4 - t3, t5 - t4} !== {32'd104, 32'd104, 32'd104, 32'd104}) begin
      errors++;
      $display("FAIL rr_spacing got %0d %0d %0d %0d exp 104 each", t1 - t0, t3 - t1, t4 - t3, t5 - t4);
    end
    wait_done(td, pr, sh);
  endtask
  task automatic test_xfer;
    int g, t, td;
    logic [1:0] pr;
    logic sh;
    set_req(3, 2'd2, 64'hABC0);
    wait_grant(g, t);
    checks++;
    if (g !== 3) begin errors++; $display("FAIL xfer_grant got %0d exp 3", g); end
    step;
    snoop_shared = 1'b1;
    snoop_supply = 1'b1;
    step;
    snoop_shared = 1'b0;
    snoop_supply = 1'b0;
    wait_done(td, pr, sh);
    checks++;
    if (td - t !== 11) begin errors++; $display("FAIL xfer_latency got %0d exp 11", td - t); end
    checks++;
    if ({pr, sh} !== {2'd3, 1'b1}) begin errors++; $display("FAIL xfer_done got proc=%0d sh=%b exp proc=3 sh=1", pr, sh); end
  endtask
  task automatic test_upg_none;
    int g, t, td, stray;
    logic [1:0] pr;
    logic sh;
    set_req(0, 2'd0, 64'h0);
    set_req(1, 2'd3, 64'h40);
    wait_grant(g, t);
    checks++;
    if (g !== 1) begin errors++; $display("FAIL upg_grant got %0d exp 1", g); end
    snoop_shared = 1'b1;
    step;
    snoop_shared = 1'b0;
    wait_done(td, pr, sh);
    checks++;
    if (td - t !== 3) begin errors++; $display("FAIL upg_latency got %0d exp 3", td - t); end
    checks++;
    if ({pr, sh} !== {2'd1, 1'b0}) begin errors++; $display("FAIL upg_done got proc=%0d sh=%b exp proc=1 sh=0", pr, sh); end
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready != 4'b0) stray++;
      step;
    end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL none_never_granted got %0d grants exp 0", stray); end
    req_valid[0] = 1'b0;
  endtask
  task automatic test_reset_mid;
    int g, t, td, dv;
    logic [1:0] pr;
    logic sh;
    set_req(2, 2'd1, 64'h2000);
    wait_grant(g, t);
    repeat (49) step;
    set_req(0, 2'd1, 64'h10);
    set_req(3, 2'd1, 64'h30);
    rst_l = 1'b0;
    #1;
    checks++;
    if ({req_ready, bus_valid, bus_op, bus_addr, bus_src, done_valid, done_proc, done_shared} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got ready=%b bv=%b op=%0d addr=%0h src=%0d dv=%b dp=%0d ds=%b exp all zero",
               req_ready, bus_valid, bus_op, bus_addr, bus_src, done_valid, done_proc, done_shared);
    end
    dv = 0;
    for (int i = 0; i < 5; i++) begin
      step;
      if (done_valid) dv++;
    end
    rst_l = 1'b1;
    wait_grant(g, t);
    checks++;
    if (g !== 0) begin errors++; $display("FAIL midreset_first_grant got %0d exp 0", g); end
    wait_done(td, pr, sh);
    checks++;
    if ({dv, td - t, 30'd0, pr} !== {32'd0, 32'd103, 30'd0, 2'd0}) begin
      errors++;
      $display("FAIL midreset_done got stray=%0d lat=%0d proc=%0d exp stray=0 lat=103 proc=0", dv, td - t, pr);
    end
    req_valid = '0;
  endtask
`ifdef SNOOP_BUS_ARB_PERF_EN
  task automatic test_perf;
    int g, t, td;
    logic [1:0] pr;
    logic sh;
    do_reset;
    checks++;
    if ({perf_txn_cnt, perf_busy_cnt} !== 64'd0) begin
      errors++;
      $display("FAIL perf_reset got txn=%0d busy=%0d exp 0 0", perf_txn_cnt, perf_busy_cnt);
    end
    for (int k = 0; k < 2; k++) begin
      set_req(2, 2'd1, 64'h3000);
      wait_grant(g, t);
      wait_done(td, pr, sh);
    end
    checks++;
    if ({perf_txn_cnt, perf_busy_cnt} !== {32'd2, 32'd206}) begin
      errors++;
      $display("FAIL perf_counts got txn=%0d busy=%0d exp 2 206", perf_txn_cnt, perf_busy_cnt);
    end
  endtask
`endif
  initial begin
    test_reset;
    test_busrd;
    test_round_robin;
    test_xfer;
    test_upg_none;
    test_reset_mid;
`ifdef SNOOP_BUS_ARB_PERF_EN
    test_perf;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
